bg_vram_fill_ctrl: RTL
======================

Name: bg_vram_fill_ctrl

Overview:
- Fill/ramp DMA engine plus write-port arbiter for the background VRAM (PMB at 12'h200–12'h3FF, NTBL at 12'h400–12'h7FF).
- Sits between the CPU bus and the background block's VRAM write interface. CPU accesses always win; the engine writes in cycles the CPU leaves free.
- Used to clear or initialise the nametable or pattern memory, or write linear ramps, without CPU store loops.

Parameters:
- ADDR_W, 12, VRAM address width (matches mapache64::vram_address_t).
- LEN_W, 11, transfer-length counter width; max transfer 2^LEN_W-1 bytes.

Ports:
- cpu_clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start_i  input  1  single-cycle request to begin a transfer; sampled only in IDLE.
- abort_i  input  1  stop the current transfer.
- base_i  input  ADDR_W  first VRAM address; latched on accepted start.
- len_i  input  LEN_W  number of bytes to write; latched on accepted start.
- value_i  input  8  first data byte; latched on accepted start.
- step_i  input  8  per-write data increment (0 = plain fill); latched on accepted start.
- cpu_req_i  input  1  CPU owns VRAM this cycle (read or write).
- cpu_address_i  input  ADDR_W  CPU address.
- cpu_wdata_i  input  8  CPU write data.
- cpu_wen_i  input  1  CPU write enable.
- vram_address_o  output  ADDR_W  muxed address to the VRAM decode/select logic.
- vram_wdata_o  output  8  muxed write data.
- vram_wen_o  output  1  muxed write enable.
- busy_o  output  1  high in RUN.
- done_o  output  1  one-cycle pulse on normal completion.
- remaining_o  output  LEN_W  bytes still to write.

Behaviour:
- Reset values:
  - state = IDLE; busy_o = 0; done_o = 0; remaining_o = 0.
  - Internal addr, data and step registers = 0.
  - Mux outputs follow the CPU inputs.
- States: IDLE, RUN.
- IDLE:
  - start_i=1 and len_i!=0: latch cur_addr=base_i, cur_data=value_i, step=step_i, remaining=len_i; go to RUN.
  - start_i=1 and len_i==0: stay in IDLE; pulse done_o in the next cycle; no writes.
- RUN, per-cycle write rule:
  - grant = ~cpu_req_i (gated further by the optional feature).
  - When grant=1, the cycle is a write: vram_address_o=cur_addr, vram_wdata_o=cur_data, vram_wen_o=1.
  - Then on posedge: cur_addr += 1 (ADDR_W wrap, 12'hFFF -> 12'h000); cur_data += step (8-bit wrap); remaining -= 1.
- RUN, stall: when grant=0, outputs pass CPU signals unchanged and engine state holds.
- RUN, completion: the write cycle with remaining==1 returns to IDLE; done_o=1 in the following cycle only.
- Latency: start accepted at edge k; first possible write is the cycle after edge k. With no CPU contention, N bytes take N consecutive cycles and done_o is high in cycle N+1.
- Mux is combinational from state, cpu_req_i and the CPU inputs. The engine never drives vram_wen_o while cpu_req_i=1.
- start_i while in RUN: ignored; latched values unchanged.
- abort_i in RUN:
  - Go to IDLE at the next edge; remaining_o cleared to 0; no done_o pulse.
  - A write granted in that same cycle still occurs.
  - abort_i has priority over completion: if both occur on the same edge, no done_o pulse.
- abort_i in IDLE: no effect.
- start_i and abort_i together in IDLE: start wins.
- Reset asserted mid-transfer: immediate return to IDLE with reset values; the partially written VRAM contents stand.
- Address range is not checked; writes outside PMB/NTBL are dropped by the downstream select decode.

Optional Feature:
- Macro: BG_FILL_VBLANK_GATE_EN.
- Defined:
  - Adds input vblank_i (1 bit).
  - grant = ~cpu_req_i & vblank_i, so engine writes occur only during vertical blank and cannot disturb the active display.
  - Stalls outside vblank hold all state.
- Undefined:
  - No vblank_i port.
  - grant = ~cpu_req_i; writes may land mid-frame.

Test Plan:
- Plain fill: base=12'h400, len=960, value=8'h00, step=0, cpu_req_i=0 -> 960 consecutive writes to 12'h400..12'h7BF, all data 0; done_o pulses in cycle 961; busy_o falls with it.
- Ramp with CPU contention: base=12'h200, len=4, value=8'hFE, step=1; cpu_req_i=1 in the 2nd and 3rd cycles -> data FE, FF, 00, 01 at 200..203; CPU address and data appear on the outputs during the stalled cycles; done_o after 6 cycles.
- Address wrap: base=12'hFFE, len=3, value=8'h11, step=0 -> writes at FFE, FFF, 000.
- Zero length and busy start: len=0 -> done_o one cycle later with no vram_wen_o. A second start during a len=10 run -> ignored; exactly 10 writes.
- Abort: abort_i after the 3rd write of len=8 -> exactly 3 or 4 writes per the same-cycle rule; remaining_o=0; done_o never pulses. Async rst_n low mid-run -> busy_o=0 immediately.
- With BG_FILL_VBLANK_GATE_EN: len=5, vblank_i low for 4 cycles then high -> no writes while low; 5 writes start on the first vblank_i=1 cycle.

Source files
------------

// File: rtl/bg_vram_fill_ctrl.sv
// Fill/ramp DMA engine and CPU-priority write-port arbiter for background VRAM.
// Optional macro BG_FILL_VBLANK_GATE_EN adds vblank_i and restricts engine writes to vertical blank.
module bg_vram_fill_ctrl #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 11
) (
  input  logic              cpu_clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [7:0]        value_i,
  input  logic [7:0]        step_i,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_address_i,
  input  logic [7:0]        cpu_wdata_i,
  input  logic              cpu_wen_i,
`ifdef BG_FILL_VBLANK_GATE_EN
  input  logic              vblank_i,
`endif
  output logic [ADDR_W-1:0] vram_address_o,
  output logic [7:0]        vram_wdata_o,
  output logic              vram_wen_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  remaining_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        step_q;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              done_q;
  logic              slot_free;
  logic              grant;

  // The CPU always owns the port when it asks; the engine only uses idle cycles.
`ifdef BG_FILL_VBLANK_GATE_EN
  assign slot_free = ~cpu_req_i & vblank_i;
`else
  assign slot_free = ~cpu_req_i;
`endif

  assign grant       = (state_q == RUN) & slot_free;
  assign addr_d      = addr_q + ADDR_W'(1);
  assign data_d      = data_q + step_q;
  assign remaining_d = remaining_q - LEN_W'(1);

  always_comb begin
    vram_address_o = cpu_address_i;
    vram_wdata_o   = cpu_wdata_i;
    vram_wen_o     = cpu_wen_i;
    if (grant) begin
      vram_address_o = addr_q;
      vram_wdata_o   = data_q;
      vram_wen_o     = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              addr_q      <= base_i;
              data_q      <= value_i;
              step_q      <= step_i;
              remaining_q <= len_i;
              state_q     <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort outranks completion; a write granted this cycle has already gone out.
          if (abort_i) begin
            remaining_q <= '0;
            state_q     <= IDLE;
          end else if (grant) begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            if (remaining_q == LEN_W'(1)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;
  assign remaining_o = remaining_q;

endmodule
